// File: rtl/sync_fifo_flex_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_flex_if
// Handshake and status bundle for sync_fifo_flex.
//   master modport : producer/consumer side. It drives enqueue, data_in and
//                    dequeue, and observes data and status.
//   slave modport  : FIFO side. It observes the requests and drives data_out,
//                    data_valid, the occupancy flags, count and the sticky
//                    error flags.
// The WIDTH and ADDRWIDTH values must match the FIFO instance that uses it.
// ---------------------------------------------------------------------------
interface sync_fifo_flex_if #(
    parameter int WIDTH     = 12,
    parameter int ADDRWIDTH = 10
);
    logic                 enqueue;
    logic [WIDTH-1:0]     data_in;
    logic                 dequeue;
    logic [WIDTH-1:0]     data_out;
    logic                 data_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDRWIDTH:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output enqueue, data_in, dequeue,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  enqueue, data_in, dequeue,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// ---------------------------------------------------------------------------
// sync_fifo_flex
// Parametrised synchronous FIFO built on inferred dual-port RAM. It has a
// standard read mode and a first-word-fall-through (FWFT) read mode, an
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
// Ports:
//   clock : rising-edge system clock
//   reset : synchronous, active-high reset
//   bus   : sync_fifo_flex_if.slave
//           (enqueue, data_in, dequeue  -> in;
//            data_out, data_valid, full, empty, almost_full, almost_empty,
//            count, overflow, underflow -> out)
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module sync_fifo_flex #(
    parameter int WIDTH     = 12,
    parameter int ADDRWIDTH = 10,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = (2 ** ADDRWIDTH) - 4,
    parameter int AE_THRESH = 4
) (
    input  logic              clock,
    input  logic              reset,
    sync_fifo_flex_if.slave   bus
);

    localparam int                 DEPTH     = 2 ** ADDRWIDTH;
    localparam bit                 FWFT_MODE = (FWFT != 0);
    localparam logic [ADDRWIDTH:0] DEPTH_C   = (ADDRWIDTH + 1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] AF_C      = (ADDRWIDTH + 1)'(AF_THRESH);
    localparam logic [ADDRWIDTH:0] AE_C      = (ADDRWIDTH + 1)'(AE_THRESH);
    localparam logic [ADDRWIDTH:0] ZERO_C    = {(ADDRWIDTH + 1){1'b0}};
    localparam logic [ADDRWIDTH:0] ONE_C     = {{ADDRWIDTH{1'b0}}, 1'b1};

    // Occupancy flags decoded from a count value: {full, empty, af, ae}.
    function automatic logic [3:0] decode_flags(input logic [ADDRWIDTH:0] cnt);
        decode_flags = {(cnt == DEPTH_C), (cnt == ZERO_C), (cnt >= AF_C), (cnt <= AE_C)};
    endfunction

    localparam logic [3:0] RESET_FLAGS_C = decode_flags(ZERO_C);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [ADDRWIDTH:0]   wr_ptr_r;
    logic [ADDRWIDTH:0]   rd_ptr_r;
    logic [ADDRWIDTH:0]   count_r;
    logic [ADDRWIDTH:0]   count_next_s;
    logic                 full_r;
    logic                 empty_r;
    logic                 af_r;
    logic                 ae_r;
    logic                 ovf_r;
    logic                 unf_r;
    logic [WIDTH-1:0]     data_out_r;
    logic                 valid_r;
    // FWFT prefetch stage: holds the word read from RAM until the output
    // register is free to take it.
    logic [WIDTH-1:0]     mid_r;
    logic                 mid_valid_r;

    logic                 enq_acc_s;
    logic                 pop_s;
    logic                 ram_rd_s;
    logic                 ram_has_s;
    logic                 out_free_s;
    logic                 mid_move_s;

    // The RAM holds unread words whenever the pointers differ. In FWFT mode
    // the read pointer advances on prefetch, not on pop, so this excludes
    // words already sitting in mid_r or data_out_r.
    assign ram_has_s = (wr_ptr_r != rd_ptr_r);

    // Acceptance, prefetch control and next count.
    always_comb begin
        enq_acc_s  = bus.enqueue && !full_r;
        pop_s      = 1'b0;
        out_free_s = 1'b0;
        mid_move_s = 1'b0;
        ram_rd_s   = 1'b0;
        if (FWFT_MODE) begin
            pop_s      = bus.dequeue && valid_r;
            out_free_s = !valid_r || pop_s;
            mid_move_s = out_free_s && mid_valid_r;
            // Refill mid_r when it is empty or is moving into the output
            // register this cycle. This keeps a throughput of one word per cycle.
            ram_rd_s   = ram_has_s && (!mid_valid_r || mid_move_s);
        end else begin
            pop_s      = bus.dequeue && !empty_r;
            ram_rd_s   = pop_s;
        end
        case ({enq_acc_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, count, occupancy flags and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            count_r  <= ZERO_C;
            {full_r, empty_r, af_r, ae_r} <= RESET_FLAGS_C;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            if (enq_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (ram_rd_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            count_r <= count_next_s;
            {full_r, empty_r, af_r, ae_r} <= decode_flags(count_next_s);
            if (bus.enqueue && full_r) begin
                ovf_r <= 1'b1;
            end
            if (bus.dequeue && !pop_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    // RAM write port. Contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (enq_acc_s) begin
            mem_r[wr_ptr_r[ADDRWIDTH-1:0]] <= bus.data_in;
        end
    end

    // RAM read port and output stage. A pending read or prefetched word is
    // dropped on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_r  <= {WIDTH{1'b0}};
            valid_r     <= 1'b0;
            mid_r       <= {WIDTH{1'b0}};
            mid_valid_r <= 1'b0;
        end else if (FWFT_MODE) begin
            if (ram_rd_s) begin
                mid_r <= mem_r[rd_ptr_r[ADDRWIDTH-1:0]];
            end
            mid_valid_r <= ram_rd_s || (mid_valid_r && !mid_move_s);
            // The output register changes only when it is free, so data_out stays
            // stable while a word waits for dequeue.
            if (out_free_s) begin
                valid_r <= mid_valid_r;
                if (mid_valid_r) begin
                    data_out_r <= mid_r;
                end
            end
        end else begin
            valid_r     <= pop_s;
            mid_valid_r <= 1'b0;
            if (pop_s) begin
                data_out_r <= mem_r[rd_ptr_r[ADDRWIDTH-1:0]];
            end
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.data_valid   = valid_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = af_r;
    assign bus.almost_empty = ae_r;
    assign bus.count        = count_r;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flex
// Directed bench with two depth-8 FIFOs. dut_a uses standard read mode with
// AF_THRESH=6 and AE_THRESH=2. dut_b uses FWFT mode with the default
// thresholds. Inputs are driven 1 time unit after each rising edge, and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flex;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    sync_fifo_flex_if #(.WIDTH(12), .ADDRWIDTH(3)) bus_a ();
    sync_fifo_flex_if #(.WIDTH(12), .ADDRWIDTH(3)) bus_b ();

    sync_fifo_flex #(.WIDTH(12), .ADDRWIDTH(3), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a));

    sync_fifo_flex #(.WIDTH(12), .ADDRWIDTH(3), .FWFT(1))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.enqueue = 1'b0; bus_a.dequeue = 1'b0; bus_a.data_in = 12'h000;
        bus_b.enqueue = 1'b0; bus_b.dequeue = 1'b0; bus_b.data_in = 12'h000;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        tests++; if (bus_a.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", bus_a.empty); end
        tests++; if (bus_a.full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", bus_a.full); end
        tests++; if (bus_a.count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", bus_a.count); end
        tests++; if (bus_a.data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus_a.data_valid); end
        tests++; if (bus_a.almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae got=%b exp=1", bus_a.almost_empty); end
        tests++; if (bus_a.almost_full !== 1'b0) begin fails++; $display("FAIL reset_af got=%b exp=0", bus_a.almost_full); end
        tests++; if ({bus_a.overflow, bus_a.underflow} !== 2'b00) begin fails++; $display("FAIL reset_errs got=%b exp=00", {bus_a.overflow, bus_a.underflow}); end
        tests++; if (bus_a.data_out !== 12'h000) begin fails++; $display("FAIL reset_dout got=%h exp=000", bus_a.data_out); end
        tests++; if ({bus_b.data_valid, bus_b.empty} !== 2'b01) begin fails++; $display("FAIL reset_fwft got=%b exp=01", {bus_b.data_valid, bus_b.empty}); end
    endtask

    // Fill to DEPTH with threshold checks, overflow on the 9th word, then drain.
    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            bus_a.enqueue = 1'b1; bus_a.data_in = 12'(i);
            tick();
            tests++; if (bus_a.count !== 4'(i)) begin fails++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus_a.count, i); end
            tests++; if (bus_a.almost_full !== (i >= 6)) begin fails++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, bus_a.almost_full, (i >= 6)); end
            tests++; if (bus_a.almost_empty !== (i <= 2)) begin fails++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, bus_a.almost_empty, (i <= 2)); end
            tests++; if (bus_a.full !== (i == 8)) begin fails++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus_a.full, (i == 8)); end
        end
        tests++; if (bus_a.overflow !== 1'b0) begin fails++; $display("FAIL pre_overflow got=%b exp=0", bus_a.overflow); end
        bus_a.data_in = 12'h009;
        tick();
        bus_a.enqueue = 1'b0;
        tests++; if (bus_a.overflow !== 1'b1) begin fails++; $display("FAIL overflow got=%b exp=1", bus_a.overflow); end
        tests++; if (bus_a.count !== 4'd8) begin fails++; $display("FAIL ovf_count got=%0d exp=8", bus_a.count); end
        for (int i = 1; i <= 8; i++) begin
            bus_a.dequeue = 1'b1;
            tick();
            tests++; if (bus_a.data_valid !== 1'b1) begin fails++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, bus_a.data_valid); end
            tests++; if (bus_a.data_out !== 12'(i)) begin fails++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, bus_a.data_out, 12'(i)); end
        end
        bus_a.dequeue = 1'b0;
        tick();
        tests++; if (bus_a.empty !== 1'b1) begin fails++; $display("FAIL drain_empty got=%b exp=1", bus_a.empty); end
        tests++; if (bus_a.data_valid !== 1'b0) begin fails++; $display("FAIL drain_valid_low got=%b exp=0", bus_a.data_valid); end
        tests++; if (bus_a.data_out !== 12'h008) begin fails++; $display("FAIL dout_hold got=%h exp=008", bus_a.data_out); end
    endtask

    // When the FIFO is full, a simultaneous dequeue is accepted and the enqueue is dropped.
    task automatic test_full_simul();
        pulse_reset();
        for (int i = 1; i <= 8; i++) begin
            bus_a.enqueue = 1'b1; bus_a.data_in = 12'(12'h100 + i);
            tick();
        end
        bus_a.data_in = 12'h999; bus_a.dequeue = 1'b1;
        tick();
        bus_a.enqueue = 1'b0;
        tests++; if (bus_a.count !== 4'd7) begin fails++; $display("FAIL fsim_count got=%0d exp=7", bus_a.count); end
        tests++; if (bus_a.overflow !== 1'b1) begin fails++; $display("FAIL fsim_ovf got=%b exp=1", bus_a.overflow); end
        tests++; if (bus_a.data_out !== 12'h101) begin fails++; $display("FAIL fsim_first got=%h exp=101", bus_a.data_out); end
        for (int i = 2; i <= 8; i++) begin
            tick();
            tests++; if (bus_a.data_out !== 12'(12'h100 + i)) begin fails++; $display("FAIL fsim_data[%0d] got=%h exp=%h", i, bus_a.data_out, 12'(12'h100 + i)); end
        end
        bus_a.dequeue = 1'b0;
        tick();
        tests++; if (bus_a.empty !== 1'b1) begin fails++; $display("FAIL fsim_empty got=%b exp=1", bus_a.empty); end
    endtask

    // Dequeue on an empty FIFO raises the sticky underflow flag; enqueue together with dequeue on empty.
    task automatic test_underflow();
        pulse_reset();
        bus_a.dequeue = 1'b1;
        tick();
        bus_a.dequeue = 1'b0;
        tests++; if (bus_a.underflow !== 1'b1) begin fails++; $display("FAIL underflow got=%b exp=1", bus_a.underflow); end
        tests++; if (bus_a.data_valid !== 1'b0) begin fails++; $display("FAIL unf_valid got=%b exp=0", bus_a.data_valid); end
        tick(); tick(); tick();
        tests++; if (bus_a.underflow !== 1'b1) begin fails++; $display("FAIL unf_sticky got=%b exp=1", bus_a.underflow); end
        pulse_reset();
        bus_a.enqueue = 1'b1; bus_a.dequeue = 1'b1; bus_a.data_in = 12'h055;
        tick();
        bus_a.enqueue = 1'b0;
        tests++; if ({bus_a.count, bus_a.underflow, bus_a.data_valid} !== {4'd1, 1'b1, 1'b0}) begin
            fails++; $display("FAIL esim got=%0d/%b/%b exp=1/1/0", bus_a.count, bus_a.underflow, bus_a.data_valid); end
        tick();
        bus_a.dequeue = 1'b0;
        tests++; if (bus_a.data_out !== 12'h055) begin fails++; $display("FAIL esim_data got=%h exp=055", bus_a.data_out); end
        tests++; if (bus_a.count !== 4'd0) begin fails++; $display("FAIL esim_count got=%0d exp=0", bus_a.count); end
    endtask

    // Run 20 rounds of 5 enqueues followed by 5 dequeues, so the pointers wrap many times.
    task automatic test_wrap();
        int val = 0;
        int full_seen = 0;
        pulse_reset();
        tick();
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 5; k++) begin
                bus_a.enqueue = 1'b1; bus_a.data_in = 12'(val + k + 12'h200);
                tick();
                if (bus_a.full) full_seen++;
            end
            bus_a.enqueue = 1'b0;
            for (int k = 0; k < 5; k++) begin
                bus_a.dequeue = 1'b1;
                tick();
                if (bus_a.full) full_seen++;
                tests++; if (bus_a.data_out !== 12'(val + k + 12'h200)) begin
                    fails++; $display("FAIL wrap_data[%0d.%0d] got=%h exp=%h", r, k, bus_a.data_out, 12'(val + k + 12'h200)); end
            end
            bus_a.dequeue = 1'b0;
            tests++; if (bus_a.count !== 4'd0) begin fails++; $display("FAIL wrap_count[%0d] got=%0d exp=0", r, bus_a.count); end
            val += 5;
        end
        tests++; if (full_seen !== 0) begin fails++; $display("FAIL wrap_full got=%0d exp=0", full_seen); end
    endtask

    // Assert reset while the FIFO is filling and enqueue is still high.
    task automatic test_reset_midfill();
        pulse_reset();
        bus_a.dequeue = 1'b1;
        tick();
        bus_a.dequeue = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_a.enqueue = 1'b1; bus_a.data_in = 12'(i);
            tick();
        end
        bus_a.data_in = 12'h0ee;
        tick();
        tick();
        tests++; if ({bus_a.overflow, bus_a.underflow, bus_a.almost_full} !== 3'b111) begin
            fails++; $display("FAIL premid got=%b exp=111", {bus_a.overflow, bus_a.underflow, bus_a.almost_full}); end
        bus_a.dequeue = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_a.enqueue = 1'b0; bus_a.dequeue = 1'b0;
        tests++; if (bus_a.count !== 4'd0) begin fails++; $display("FAIL mid_count got=%0d exp=0", bus_a.count); end
        tests++; if ({bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty} !== 4'b0101) begin
            fails++; $display("FAIL mid_flags got=%b exp=0101", {bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty}); end
        tests++; if ({bus_a.overflow, bus_a.underflow, bus_a.data_valid} !== 3'b000) begin
            fails++; $display("FAIL mid_errs got=%b exp=000", {bus_a.overflow, bus_a.underflow, bus_a.data_valid}); end
    endtask

    // FWFT mode: a single word appears two edges after it is written, stays put, then is popped.
    task automatic test_fwft_single();
        pulse_reset();
        bus_b.enqueue = 1'b1; bus_b.data_in = 12'hABC;
        tick();                                   // edge N
        bus_b.enqueue = 1'b0;
        tests++; if (bus_b.data_valid !== 1'b0) begin fails++; $display("FAIL fwft_n0 got=%b exp=0", bus_b.data_valid); end
        tick();                                   // edge N+1
        tests++; if (bus_b.data_valid !== 1'b0) begin fails++; $display("FAIL fwft_n1 got=%b exp=0", bus_b.data_valid); end
        tick();                                   // edge N+2
        tests++; if (bus_b.data_valid !== 1'b1) begin fails++; $display("FAIL fwft_n2 got=%b exp=1", bus_b.data_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if ({bus_b.data_valid, bus_b.data_out} !== {1'b1, 12'hABC}) begin
                fails++; $display("FAIL fwft_hold[%0d] got=%b/%h exp=1/abc", i, bus_b.data_valid, bus_b.data_out); end
        end
        tests++; if (bus_b.count !== 4'd1) begin fails++; $display("FAIL fwft_count1 got=%0d exp=1", bus_b.count); end
        bus_b.dequeue = 1'b1;
        tick();
        tests++; if ({bus_b.data_valid, bus_b.count, bus_b.underflow} !== {1'b0, 4'd0, 1'b0}) begin
            fails++; $display("FAIL fwft_pop got=%b/%0d/%b exp=0/0/0", bus_b.data_valid, bus_b.count, bus_b.underflow); end
        tick();
        bus_b.dequeue = 1'b0;
        tests++; if (bus_b.underflow !== 1'b1) begin fails++; $display("FAIL fwft_unf got=%b exp=1", bus_b.underflow); end
    endtask

    // FWFT mode: 100 words streamed with enqueue every cycle and dequeue whenever data_valid.
    task automatic test_fwft_stream();
        int sent = 0;
        int rcv  = 0;
        int seen = 0;
        int gaps = 0;
        int maxc = 0;
        pulse_reset();
        for (int cyc = 0; cyc < 400 && rcv < 100; cyc++) begin
            if (bus_b.data_valid) begin
                seen = 1;
                tests++; if (bus_b.data_out !== 12'(rcv + 12'h300)) begin
                    fails++; $display("FAIL stream_data[%0d] got=%h exp=%h", rcv, bus_b.data_out, 12'(rcv + 12'h300)); end
                rcv++;
                bus_b.dequeue = 1'b1;
            end else begin
                if (seen != 0) gaps++;
                bus_b.dequeue = 1'b0;
            end
            if (sent < 100) begin
                bus_b.enqueue = 1'b1; bus_b.data_in = 12'(sent + 12'h300); sent++;
            end else begin
                bus_b.enqueue = 1'b0;
            end
            if (int'(bus_b.count) > maxc) maxc = int'(bus_b.count);
            tick();
        end
        bus_b.enqueue = 1'b0; bus_b.dequeue = 1'b0;
        tests++; if (rcv !== 100) begin fails++; $display("FAIL stream_rcv got=%0d exp=100", rcv); end
        tests++; if (gaps !== 0) begin fails++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
        tests++; if (maxc > 3) begin fails++; $display("FAIL stream_maxcount got=%0d exp<=3", maxc); end
        tests++; if ({bus_b.empty, bus_b.data_valid, bus_b.underflow, bus_b.overflow} !== 4'b1000) begin
            fails++; $display("FAIL stream_end got=%b exp=1000", {bus_b.empty, bus_b.data_valid, bus_b.underflow, bus_b.overflow}); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_full_simul();
        test_underflow();
        test_wrap();
        test_reset_midfill();
        test_fwft_single();
        test_fwft_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised synchronous FIFO that succeeds the fixed-IP audio sample FIFO. It uses inferred dual-port RAM, so it has no vendor core dependency. It adds a selectable first-word-fall-through read mode, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between pitch-shifter pipeline stages and between the sample stream and the frame buffers.

Parameters:
WIDTH, 12, data word width in bits.
ADDRWIDTH, 10, log2 of depth; DEPTH = 2**ADDRWIDTH words.
FWFT, 0, 0 = standard read mode (data 1 cycle after dequeue); 1 = first-word-fall-through.
AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enqueue  in  1  write request.
data_in  in  WIDTH  write data.
dequeue  in  1  read request (standard mode) or pop/acknowledge (FWFT).
data_out  out  WIDTH  read data.
data_valid  out  1  data_out holds a valid word.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
count  out  ADDRWIDTH+1  words held: enqueued and not yet consumed, including any word in the FWFT output stage.
overflow  out  1  sticky: enqueue was attempted while full.
underflow  out  1  sticky: dequeue was attempted with nothing to read.

Behaviour:
- Reset (synchronous, 1 cycle, valid at any time, including mid-burst):
  - Pointers, count, data_valid, overflow and underflow are cleared to 0; data_out is cleared to 0.
  - full=0, empty=1, almost_empty=1, almost_full=(AF_THRESH==0).
  - RAM contents are not cleared.
  - Pending reads are discarded; data_valid is 0 on the cycle after reset.
- Pointers:
  - ADDRWIDTH+1 bits each; the MSB is the wrap bit.
  - Each pointer increments only on an accepted operation and wraps naturally from DEPTH-1 to 0.
- Enqueue acceptance:
  - Accepted iff enqueue && !full; data_in is written at the write pointer.
  - If enqueue && full: no write, no pointer or count change, and overflow is set.
- Count:
  - Registered; +1 on an accepted enqueue only, -1 on an accepted dequeue only, unchanged when both are accepted.
  - full, empty, almost_full and almost_empty decode from the registered count, so they update the cycle after the event.
- Standard mode (FWFT=0):
  - Dequeue is accepted iff dequeue && !empty.
  - RAM read is registered: data_out and data_valid=1 appear exactly 1 cycle after the accepted dequeue; otherwise data_valid=0 on the next cycle.
  - data_out holds its last value when not updated.
  - dequeue && empty sets underflow; no pointer change.
- FWFT mode (FWFT=1):
  - The head word is presented on data_out with data_valid=1 without a request.
  - Dequeue is accepted iff dequeue && data_valid; it consumes the head.
  - Internal prefetch (RAM register plus output register/skid) is implementation-free, but these cycle rules are required:
    - First-word latency: when enqueue is accepted at edge N into an empty FIFO, data_valid=1 from edge N+2.
    - With continuous accepted enqueues and dequeue asserted whenever data_valid, data_valid stays high every cycle after the first word (1 word/cycle throughput).
    - data_out is stable while data_valid && !dequeue.
    - dequeue && !data_valid sets underflow.
- Simultaneous enqueue and dequeue:
  - When full: dequeue is accepted, enqueue is rejected and overflow is set.
  - When empty (standard mode): enqueue is accepted, dequeue is rejected and underflow is set.
  - Otherwise both are accepted and count is unchanged.
- Ordering: strict FIFO order across any number of pointer wraps.
- Read-during-write to the same RAM address cannot occur, because empty/valid gating prevents it; no bypass path is required.

Test Plan:
- Reset then idle, ADDRWIDTH=3, FWFT=0 -> empty=1, full=0, count=0, data_valid=0, almost_empty=1, overflow=0, underflow=0.
- Standard mode: enqueue 0x001..0x008 (DEPTH 8), then 1 more -> full=1, count=8, overflow=1, the 9th word dropped. Dequeue 8 times -> data_out 0x001..0x008, each 1 cycle after its dequeue; then empty=1.
- Wrap: 20 rounds of enqueue 5/dequeue 5 with an incrementing pattern -> no data mismatch; count returns to 0 each round; full never asserts.
- FWFT=1: single enqueue 0xABC at edge N -> data_valid=1 and data_out=0xABC from edge N+2. Hold dequeue=0 for 5 cycles -> stable. Pop -> data_valid=0, count=0.
- FWFT=1 streaming: enqueue every cycle and dequeue whenever valid for 100 words -> data_valid continuous after the first word; output sequence equals input; count never exceeds 3.
- Thresholds/errors, AF_THRESH=6, AE_THRESH=2:
  - Fill to 6 -> almost_full=1 the cycle after the 6th write; 3 words -> almost_empty=0.
  - Dequeue when empty -> underflow=1, which stays 1.
  - Assert reset mid-fill -> all flags and count return to their reset values next cycle.
